// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between a producer and the UART transmit serializer.
// The producer drives tx_data/tx_valid; the serializer answers with tx_ready.
interface uart_tx_serializer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Bit timing comes from an internal down-counting baud counter; line idles high.
module uart_tx_serializer #(
    parameter int TICKS_PER_BIT = 10416,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    uart_tx_serializer_if.slave  tx,
    output logic                 txd,
    output logic                 busy
);

    localparam int CNT_W = $clog2(TICKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(TICKS_PER_BIT - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_idx;
    logic             stop_idx;
    logic             par_bit;
    logic             ready_r;

    assign tx.tx_ready = ready_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            shift_reg <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            par_bit   <= 1'b0;
            txd       <= 1'b1;
            busy      <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (tx.tx_valid) begin
                        shift_reg <= tx.tx_data;
                        par_bit   <= (PARITY == 1) ? ~^tx.tx_data : ^tx.tx_data;
                        baud_cnt  <= BIT_LOAD;
                        state     <= START;
                        txd       <= 1'b0;
                        busy      <= 1'b1;
                        ready_r   <= 1'b0;
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BIT_LOAD;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                        txd      <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BIT_LOAD;
                        if (bit_idx == 3'd7) begin
                            if (PARITY != 0) begin
                                state <= PAR;
                                txd   <= par_bit;
                            end else begin
                                state    <= STOP;
                                stop_idx <= 1'b0;
                                txd      <= 1'b1;
                            end
                        end else begin
                            // txd mirrors shift_reg[0] after the shift, i.e. the next data bit
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            txd       <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                PAR: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BIT_LOAD;
                        stop_idx <= 1'b0;
                        state    <= STOP;
                        txd      <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == '0) begin
                        if (stop_idx == LAST_STOP) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            ready_r <= 1'b1;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                            baud_cnt <= BIT_LOAD;
                        end
                        txd <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    txd     <= 1'b1;
                    busy    <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule
